// File: rtl/mod_arith_pkg.sv
// Shared modular-arithmetic definitions for the add/sub, mul and butterfly blocks.
// Lane packing: lane i of a vector sits at bits [i*w +: w].
package mod_arith_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int LANE_WMAX = 64;
  localparam int VEC_WMAX  = 1024;

  typedef logic [VEC_WMAX-1:0]  vec_t;
  typedef logic [LANE_WMAX-1:0] word_t;

  // Callers size-cast the result down to their own lane width.
  function automatic word_t lane(
    input vec_t vec,
    input int   i,
    input int   w
  );
    return word_t'(vec >> (i * w));
  endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// Final modular correction for one lane: folds the S1 sum/difference into [0, q-1].
// Add path subtracts q at WIDTH+2 bits so q = 2^WIDTH-1 never overflows.
module mod_addsub_lane
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   s,
  input  logic [WIDTH-1:0] q,
  input  logic             sub,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH+1:0] t;
  logic [WIDTH-1:0] u;
  logic             unused_t;

  assign unused_t = t[WIDTH];

  always_comb begin
    t = {1'b0, s} - {2'b00, q};
    u = s[WIDTH-1:0] + q;
    c = s[WIDTH-1:0];
    if (sub == MODE_SUB) begin
      if (s[WIDTH]) c = u;
    end else if (!t[WIDTH+1]) begin
      c = t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage multi-lane modular adder/subtractor with valid/ready backpressure.
// Define MOD_ADDSUB_RANGE_CHK_EN to add the out_err operand range flag.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [WIDTH-1:0]       in_mod,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_c,
  output logic                   out_sub
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  ,
  output logic                   out_err
`endif
);

  logic             v1;
  logic             sub1;
  logic [WIDTH-1:0] q1;
  logic [WIDTH:0]   s1 [LANES];
  logic             s1_load;
  logic             s2_load;

  logic [WIDTH-1:0] a_l [LANES];
  logic [WIDTH-1:0] b_l [LANES];
  logic [WIDTH-1:0] c_l [LANES];

  assign s2_load  = (!out_valid || out_ready) && v1;
  assign s1_load  = !v1 || s2_load;
  assign in_ready = !v1 || !out_valid || out_ready;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_l[i] = WIDTH'(lane(vec_t'(in_a), i, WIDTH));
      b_l[i] = WIDTH'(lane(vec_t'(in_b), i, WIDTH));
    end
  end

`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic rng_err;
  logic err1;

  always_comb begin
    rng_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (a_l[i] >= in_mod || b_l[i] >= in_mod) rng_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err1    <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (s1_load && in_valid) err1 <= rng_err;
      if (s2_load) out_err <= err1;
    end
  end
`endif

  // S1: raw sum/difference at WIDTH+1 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      sub1 <= MODE_ADD;
      q1   <= '0;
      for (int i = 0; i < LANES; i++) s1[i] <= '0;
    end else if (s1_load) begin
      v1 <= in_valid;
      if (in_valid) begin
        sub1 <= in_sub;
        q1   <= in_mod;
        for (int i = 0; i < LANES; i++) begin
          if (in_sub == MODE_SUB)
            s1[i] <= {1'b0, a_l[i]} - {1'b0, b_l[i]};
          else
            s1[i] <= {1'b0, a_l[i]} + {1'b0, b_l[i]};
        end
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_addsub_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .s  (s1[g]),
      .q  (q1),
      .sub(sub1),
      .c  (c_l[g])
    );
  end

  // S2: corrected result, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sub   <= 1'b0;
      out_c     <= '0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_sub   <= sub1;
      for (int i = 0; i < LANES; i++) out_c[i*WIDTH +: WIDTH] <= c_l[i];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed table, backpressure,
// reset and randomized traffic against a plain-arithmetic reference model.
module tb_mod_addsub_pipe;

  localparam int W = 32;
  localparam int L = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_sub;
  logic [W-1:0]   in_mod;
  logic [L*W-1:0] in_a;
  logic [L*W-1:0] in_b;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] out_c;
  logic           out_sub;
`ifdef MOD_ADDSUB_RANGE_CHK_EN
  logic           out_err;
`endif

  mod_addsub_pipe #(
    .WIDTH(W),
    .LANES(L)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sub   (in_sub),
    .in_mod   (in_mod),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c),
    .out_sub  (out_sub)
`ifdef MOD_ADDSUB_RANGE_CHK_EN
    ,
    .out_err  (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] x0, x1, x2, x3);
    return {x3, x2, x1, x0};
  endfunction

  typedef struct packed {
    logic         sub;
    logic [31:0]  q;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
  } vec_s;

  typedef struct packed {
    logic [127:0] c;
    logic         sub;
  } exp_t;

  // Reference: plain modular arithmetic on 64-bit integers
  function automatic exp_t model(input logic sub, input logic [31:0] q,
                                 input logic [127:0] a, b);
    exp_t   e;
    longint la, lb, lq, r;
    e.sub = sub;
    e.c   = '0;
    lq    = longint'({32'd0, q});
    for (int i = 0; i < L; i++) begin
      la = longint'({32'd0, a[i*W +: W]});
      lb = longint'({32'd0, b[i*W +: W]});
      r  = sub ? (la - lb + lq) % lq : (la + lb) % lq;
      e.c[i*W +: W] = r[31:0];
    end
    return e;
  endfunction

  exp_t q_exp[$];
  logic mon_en = 1'b0;
  int   out_cnt = 0;
  logic prev_stall = 1'b0;
  logic [127:0] prev_c;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_c", out_c, prev_c);
      end
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          chk("stream_c", out_c, e.c);
          chk("stream_sub", out_sub, e.sub);
        end
        out_cnt++;
      end
      if (in_valid && in_ready)
        q_exp.push_back(model(in_sub, in_mod, in_a, in_b));
      prev_stall = out_valid && !out_ready;
      prev_c     = out_c;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rand_beat(output logic sub, output logic [31:0] q,
                           output logic [127:0] a, b);
    q = $urandom;
    if ($urandom_range(0, 7) == 0) q = 32'hFFFF_FFFF;
    if (q < 2) q = 2;
    sub = 1'($urandom_range(0, 1));
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = $urandom % q;
      b[i*W +: W] = $urandom % q;
    end
  endtask

  vec_s tv[6];
  logic bp_sub [8];
  logic [31:0] bp_q [8];
  logic [127:0] bp_a [8];
  logic [127:0] bp_b [8];

  initial begin
    logic fired;
    int   sent;

    tv[0] = '{1'b0, 32'd12289, pk(12288, 5, 0, 6000), pk(12288, 7, 0, 6289),
              pk(12287, 12, 0, 0)};
    tv[1] = '{1'b1, 32'd12289, pk(0, 5, 100, 12288), pk(12288, 7, 100, 0),
              pk(1, 12287, 0, 12288)};
    tv[2] = '{1'b0, 32'hFFFF_FFFF,
              pk(32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFE),
              pk(32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 1),
              pk(32'hFFFF_FFFD, 0, 32'hFFFF_FFFE, 0)};
    tv[3] = '{1'b1, 32'hFFFF_FFFF,
              pk(0, 0, 5, 32'hFFFF_FFFE),
              pk(32'hFFFF_FFFE, 0, 5, 0),
              pk(1, 0, 0, 32'hFFFF_FFFE)};
    tv[4] = '{1'b0, 32'd2, pk(1, 1, 0, 0), pk(1, 0, 1, 0), pk(0, 1, 1, 0)};
    tv[5] = '{1'b1, 32'd2, pk(0, 1, 0, 1), pk(1, 1, 0, 0), pk(1, 0, 0, 1)};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sub = 1'b0;
    in_mod = 32'd2;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_c", out_c, '0);
    chk("rst_out_sub", out_sub, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table with exact latency checks
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_sub = tv[k].sub;
      in_mod = tv[k].q;
      in_a = tv[k].a;
      in_b = tv[k].b;
      @(negedge clk);
      chk($sformatf("tv%0d_in_ready", k), in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("tv%0d_lat1", k), out_valid, 1'b0);
      @(negedge clk);
      chk($sformatf("tv%0d_lat2", k), out_valid, 1'b1);
      chk($sformatf("tv%0d_c", k), out_c, tv[k].c);
      chk($sformatf("tv%0d_sub", k), out_sub, tv[k].sub);
    end
    @(posedge clk); #1;

    // Backpressure: 8 beats, consumer stalls 5 cycles mid-stream
    for (int k = 0; k < 8; k++) begin
      logic s; logic [31:0] q; logic [127:0] a, b;
      rand_beat(s, q, a, b);
      bp_sub[k] = s; bp_q[k] = q; bp_a[k] = a; bp_b[k] = b;
    end
    q_exp.delete();
    out_cnt = 0;
    mon_en = 1'b1;
    sent = 0;
    fired = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #1;
      if (fired) sent++;
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid = (sent < 8);
      if (sent < 8) begin
        in_sub = bp_sub[sent];
        in_mod = bp_q[sent];
        in_a = bp_a[sent];
        in_b = bp_b[sent];
      end
      @(negedge clk);
      fired = in_valid && in_ready;
      if (cyc == 8) chk("bp_in_ready_low", in_ready, 1'b0);
    end
    chk("bp_count", 128'(out_cnt), 128'd8);
    chk("bp_queue_empty", 128'(q_exp.size()), 128'd0);

    // Asynchronous reset with two beats in flight
    mon_en = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sub = 1'b0;
    in_mod = 32'd12289;
    in_a = pk(1, 2, 3, 4);
    in_b = pk(5, 6, 7, 8);
    @(posedge clk); #1;
    in_a = pk(9, 9, 9, 9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_c", out_c, '0);
    chk("async_rst_sub", out_sub, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);
    q_exp.delete();
    out_cnt = 0;
    mon_en = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_sub = 1'b1;
    in_mod = 32'd97;
    in_a = pk(3, 50, 96, 0);
    in_b = pk(4, 50, 1, 96);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_count", 128'(out_cnt), 128'd1);
    chk("post_rst_queue", 128'(q_exp.size()), 128'd0);

    // Randomized traffic with random backpressure
    fired = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        logic s; logic [31:0] q; logic [127:0] a, b;
        rand_beat(s, q, a, b);
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_sub = s; in_mod = q; in_a = a; in_b = b;
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
      fired = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_drained", 128'(q_exp.size()), 128'd0);
    mon_en = 1'b0;

`ifdef MOD_ADDSUB_RANGE_CHK_EN
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sub = 1'b0;
    in_mod = 32'd12289;
    in_a = pk(1, 2, 12289, 3);
    in_b = pk(1, 2, 3, 4);
    @(posedge clk); #1;
    in_a = pk(1, 2, 3, 4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_beat_valid", out_valid, 1'b1);
    chk("err_beat_flag", out_err, 1'b1);
    @(negedge clk);
    chk("ok_beat_valid", out_valid, 1'b1);
    chk("ok_beat_flag", out_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
